hci_mem_bank_rmw: RTL and testbench
===================================

# hci_mem_bank_rmw

Per-bank memory-side controller placed directly downstream of one `mems[]` master port of the TCDM heterogeneous interconnect. It drives one single-port SRAM macro that supports only full-word writes. Byte-enabled (partial) writes are turned into an SRAM read-modify-write sequence. Every request gets a response one cycle after grant, so the upstream protocol is unchanged.

## Interface
Parameters:
- `DW`, 32, data width in bits; a multiple of `BW`.
- `BW`, 8, byte width in bits; the byte-enable width is `NB = DW/BW`.
- `AW`, 10, word address width of the bank.
- `IW`, 8, request/response ID width.

Ports:
- `clk_i` in 1: clock; all logic is on the rising edge.
- `rst_i` in 1: **asynchronous, active-high reset**.
- `clear_i` in 1: synchronous clear.
- `req_i` in 1: request valid.
- `gnt_o` out 1: grant.
- `add_i` in `AW`: word address.
- `wen_i` in 1: 1 = read, 0 = write.
- `be_i` in `NB`: byte enables.
- `data_i` in `DW`: write data.
- `id_i` in `IW`: request ID.
- `r_valid_o` out 1: response valid.
- `r_data_o` out `DW`: read data; 0 on write responses.
- `r_id_o` out `IW`: response ID.
- `sram_req_o` out 1: SRAM access strobe.
- `sram_we_o` out 1: 1 = SRAM full-word write.
- `sram_add_o` out `AW`: SRAM address.
- `sram_wdata_o` out `DW`: SRAM write data.
- `sram_rdata_i` in `DW`: SRAM read data, valid one cycle after a read strobe.
- `cnt_clr_i` in 1: clear the statistics counters.
- `cnt_rd_o`, `cnt_wr_o`, `cnt_rmw_o` out 32 each: statistics counters.

## Operation
The FSM has two states, IDLE and MERGE.

IDLE (`gnt_o = 1`, combinational; no request is refused in IDLE). When `req_i` is high:
- **Read:** SRAM read at `add_i`. Next cycle: `r_valid_o = 1`, `r_data_o = sram_rdata_i`, `r_id_o = id`.
- **Full write** (`be_i` all ones): SRAM write of `data_i`. Next cycle: write response.
- **Zero-byte write** (`be_i == 0`): no SRAM access. Next cycle: write response.
- **Partial write** (any other `be_i`):
  - Latch address, data, `be_i` and ID.
  - Issue an SRAM read at `add_i`.
  - Go to MERGE.

MERGE (one cycle only):
- `gnt_o = 0`.
- SRAM write at the latched address. The write data takes byte `k` from the latched data where `be[k] = 1`, and from `sram_rdata_i` otherwise.
- Write response is asserted in this same cycle.
- Return to IDLE.

Responses:
- A write response is `r_valid_o = 1`, `r_data_o = 0`, `r_id_o = id`.
- No response backpressure exists; at most one response is in flight.

`sram_req_o = 0` whenever no access is being issued. `sram_add_o` and `sram_wdata_o` are don't-care in those cycles.

## Timing
- Reset values: FSM in IDLE; `r_valid_o = 0`; `r_data_o = 0`; `r_id_o = 0`; `gnt_o` reads 1 out of reset; counters at 0.
- Latency is exactly 1 cycle from a granted request to `r_valid_o`, for all request types.
- After a partial write, `gnt_o` is low for exactly one cycle.
- A request held through MERGE is granted in the following cycle. Its SRAM access therefore comes after the merge write, so read-after-partial-write to the same address returns the merged data.
- `clear_i` while in MERGE: the SRAM write is suppressed, the FSM goes to IDLE, and no response is produced. `clear_i` in IDLE: any request that cycle is ignored and no response follows.
- `rst_i` while in MERGE: outputs take their reset values immediately and the pending write is lost.
- Counters are 32-bit and wrap modulo 2^32.
  - Read and full writes increment `cnt_rd_o`/`cnt_wr_o` at grant.
  - A partial write increments `cnt_wr_o` and `cnt_rmw_o` at grant.
  - Zero-byte writes increment only `cnt_wr_o`.
  - `cnt_clr_i` has priority over increments.

## Configuration
- **`HCI_MEM_BANK_STATS_EN`**
  - Defined: the three counters are implemented as specified.
  - Undefined: no counter registers are built, `cnt_*_o` are tied to 0 and `cnt_clr_i` is ignored.
  - Functional behaviour is otherwise identical in both cases.

## Test plan
- **Read:** preload address 0x10 with 0xDEADBEEF; read it with id 0x05 -> `r_valid_o` one cycle later, `r_data_o = 0xDEADBEEF`, `r_id_o = 0x05`, `gnt_o` never low.
- **Full write then read:** write 0x12345678 to 0x20 with `be = 0xF`, then read 0x20 back-to-back -> both granted consecutively; the read returns 0x12345678.
- **Partial write:** 0x30 holds 0xAABBCCDD; write 0x11223344 with `be = 0x5` and id 0x3 ->
  - `gnt_o` low for one cycle;
  - SRAM writes 0xAA22CC44;
  - `r_id_o = 0x03` one cycle after grant;
  - a following held read of 0x30 returns 0xAA22CC44.
- **Zero-byte write:** `be = 0` -> no `sram_req_o`, response still returned; `cnt_wr_o` increments by 1.
- **Reset and clear mid-MERGE:** assert `rst_i` during MERGE -> outputs at reset values and the location is unchanged; repeat with `clear_i` -> no SRAM write and no `r_valid_o`.
- **Stats:** 3 reads, 2 full writes and 1 partial write, with `HCI_MEM_BANK_STATS_EN` defined -> `cnt_rd_o = 3`, `cnt_wr_o = 3`, `cnt_rmw_o = 1`; `cnt_clr_i` then zeroes all three. Same traffic with the macro undefined -> all three counters read 0.

Source files
------------

// File: rtl/hci_mem_bank_rmw_if.sv
// -----------------------------------------------------------------------------
// hci_mem_bank_rmw_if
//
// Purpose: TCDM request/response bundle between one interconnect master port
// and the per-bank controller hci_mem_bank_rmw.
//
// Signals (names follow the bank controller's port list):
//   req_i      request valid                     (master -> slave)
//   gnt_o      grant                             (slave  -> master)
//   add_i      word address, AW bits             (master -> slave)
//   wen_i      1 = read, 0 = write               (master -> slave)
//   be_i       byte enables, NB = DW/BW bits     (master -> slave)
//   data_i     write data, DW bits               (master -> slave)
//   id_i       request ID, IW bits               (master -> slave)
//   r_valid_o  response valid                    (slave  -> master)
//   r_data_o   read data (0 on write responses)  (slave  -> master)
//   r_id_o     response ID                       (slave  -> master)
//
// Handshake: a request transfers in a cycle where req_i and gnt_o are both
// high. The response is unconditional (no backpressure): r_valid_o is a
// single-cycle pulse exactly one cycle after the transfer.
// -----------------------------------------------------------------------------
interface hci_mem_bank_rmw_if #(
  parameter int DW = 32,
  parameter int BW = 8,
  parameter int AW = 10,
  parameter int IW = 8
) ();

  localparam int NB = DW / BW;

  logic          req_i;
  logic          gnt_o;
  logic [AW-1:0] add_i;
  logic          wen_i;
  logic [NB-1:0] be_i;
  logic [DW-1:0] data_i;
  logic [IW-1:0] id_i;
  logic          r_valid_o;
  logic [DW-1:0] r_data_o;
  logic [IW-1:0] r_id_o;

  // Initiator side (interconnect / testbench driver).
  modport master (
    output req_i, add_i, wen_i, be_i, data_i, id_i,
    input  gnt_o, r_valid_o, r_data_o, r_id_o
  );

  // Target side (bank controller).
  modport slave (
    input  req_i, add_i, wen_i, be_i, data_i, id_i,
    output gnt_o, r_valid_o, r_data_o, r_id_o
  );

endinterface

// File: rtl/hci_mem_bank_rmw.sv
// -----------------------------------------------------------------------------
// hci_mem_bank_rmw
//
// Purpose: per-bank memory-side controller for one TCDM bank. It drives a
// single-port SRAM that only supports full-word writes. Partial (byte-enabled)
// writes are turned into an SRAM read followed by a merged full-word write.
// Every granted request gets its response exactly one cycle after the grant.
//
// Optional feature macro: HCI_MEM_BANK_STATS_EN
//   defined   -> 32-bit read / write / read-modify-write statistics counters
//   undefined -> no counter registers, cnt_*_o tied to 0, cnt_clr_i ignored
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-high reset
//   clear_i        synchronous clear (drops a pending merge, ignores requests)
//   tcdm           hci_mem_bank_rmw_if.slave: req/gnt/add/wen/be/data/id and
//                  r_valid/r_data/r_id
//   sram_req_o     SRAM access strobe
//   sram_we_o      1 = SRAM full-word write, 0 = read
//   sram_add_o     SRAM word address
//   sram_wdata_o   SRAM write data
//   sram_rdata_i   SRAM read data, valid one cycle after a read strobe
//   cnt_clr_i      clear statistics counters (wins over increments)
//   cnt_rd_o       granted reads
//   cnt_wr_o       granted writes (full, partial and zero-byte)
//   cnt_rmw_o      granted partial writes
//   dbg_state_o    current FSM state (0 = IDLE, 1 = MERGE)
//
// Handshake: a request transfers when req_i & gnt_o and clear_i is low.
// gnt_o is high in IDLE and low in MERGE. Responses have no backpressure;
// r_valid_o pulses for one cycle, one cycle after the transfer.
// -----------------------------------------------------------------------------
module hci_mem_bank_rmw #(
  parameter int DW = 32,
  parameter int BW = 8,
  parameter int AW = 10,
  parameter int IW = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,

  hci_mem_bank_rmw_if.slave    tcdm,

  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AW-1:0]        sram_add_o,
  output logic [DW-1:0]        sram_wdata_o,
  input  logic [DW-1:0]        sram_rdata_i,

  input  logic                 cnt_clr_i,
  output logic [31:0]          cnt_rd_o,
  output logic [31:0]          cnt_wr_o,
  output logic [31:0]          cnt_rmw_o,

  output logic [0:0]           dbg_state_o
);

  localparam int NB = DW / BW;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_MERGE = 1'b1;

  // ---------------------------------------------------------------------------
  // State and registered request/response context
  // ---------------------------------------------------------------------------
  logic [0:0]    state_q;
  logic [0:0]    state_d;

  logic [AW-1:0] add_q;      // partial write: latched address
  logic [DW-1:0] data_q;     // partial write: latched write data
  logic [NB-1:0] be_q;       // partial write: latched byte enables

  logic          r_valid_q;  // a response is due this cycle
  logic          rsp_rd_q;   // the due response belongs to a read
  logic [IW-1:0] r_id_q;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic in_idle;
  logic in_merge;
  logic accept;
  logic be_full;
  logic be_zero;
  logic acc_rd;
  logic acc_wr;
  logic acc_full;
  logic acc_part;
  logic merge_wr;

  assign in_idle  = (state_q == ST_IDLE);
  assign in_merge = (state_q == ST_MERGE);

  // clear_i in IDLE drops the request even though gnt_o stays high.
  assign accept   = in_idle & tcdm.req_i & ~clear_i;

  assign be_full  = &tcdm.be_i;
  assign be_zero  = ~|tcdm.be_i;

  assign acc_rd   = accept & tcdm.wen_i;
  assign acc_wr   = accept & ~tcdm.wen_i;
  assign acc_full = acc_wr & be_full;
  assign acc_part = acc_wr & ~be_full & ~be_zero;

  // The merge write is abandoned if clear_i arrives during MERGE.
  assign merge_wr = in_merge & ~clear_i;

  // ---------------------------------------------------------------------------
  // Byte merge: enabled lanes from the latched write data, the rest from the
  // word read out of the SRAM in the previous (grant) cycle.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] merged;

  always_comb begin
    merged = sram_rdata_i;
    for (int k = 0; k < NB; k++) begin
      if (be_q[k]) begin
        merged[k*BW +: BW] = data_q[k*BW +: BW];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // SRAM port
  // Address/data follow the incoming request in IDLE and the latched context in
  // MERGE; they are don't-care whenever sram_req_o is low.
  // ---------------------------------------------------------------------------
  always_comb begin
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_add_o   = tcdm.add_i;
    sram_wdata_o = tcdm.data_i;
    if (in_merge) begin
      sram_req_o   = merge_wr;
      sram_we_o    = merge_wr;
      sram_add_o   = add_q;
      sram_wdata_o = merged;
    end else begin
      // Partial writes start with a read of the old word; zero-byte writes
      // never touch the SRAM.
      sram_req_o = acc_rd | acc_full | acc_part;
      sram_we_o  = acc_full;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: MERGE lasts exactly one cycle, whatever clear_i does.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = ST_IDLE;
    if (in_idle && acc_part) begin
      state_d = ST_MERGE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      add_q     <= '0;
      data_q    <= '0;
      be_q      <= '0;
      r_valid_q <= 1'b0;
      rsp_rd_q  <= 1'b0;
      r_id_q    <= '0;
    end else begin
      state_q   <= state_d;
      // Every accepted request, of any type, is answered in the next cycle.
      // For a partial write that next cycle is the MERGE cycle itself.
      r_valid_q <= accept;
      rsp_rd_q  <= acc_rd;
      if (accept) begin
        r_id_q <= tcdm.id_i;
      end
      if (acc_part) begin
        add_q  <= tcdm.add_i;
        data_q <= tcdm.data_i;
        be_q   <= tcdm.be_i;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // TCDM outputs
  // ---------------------------------------------------------------------------
  assign tcdm.gnt_o     = in_idle;
  // A clear during MERGE cancels the write response due in that same cycle.
  assign tcdm.r_valid_o = r_valid_q & ~(in_merge & clear_i);
  // Read data comes straight from the SRAM output register; write responses
  // (and idle cycles) return zero.
  assign tcdm.r_data_o  = rsp_rd_q ? sram_rdata_i : '0;
  assign tcdm.r_id_o    = r_id_q;

  assign dbg_state_o    = state_q;

  // ---------------------------------------------------------------------------
  // Statistics counters
  // ---------------------------------------------------------------------------
`ifdef HCI_MEM_BANK_STATS_EN
  logic [31:0] cnt_rd_q;
  logic [31:0] cnt_wr_q;
  logic [31:0] cnt_rmw_q;

  // Counting happens at grant; a merge that is later cleared still counts.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_rd_q  <= '0;
      cnt_wr_q  <= '0;
      cnt_rmw_q <= '0;
    end else if (cnt_clr_i) begin
      cnt_rd_q  <= '0;
      cnt_wr_q  <= '0;
      cnt_rmw_q <= '0;
    end else begin
      if (acc_rd) begin
        cnt_rd_q <= cnt_rd_q + 32'd1;
      end
      if (acc_wr) begin
        cnt_wr_q <= cnt_wr_q + 32'd1;
      end
      if (acc_part) begin
        cnt_rmw_q <= cnt_rmw_q + 32'd1;
      end
    end
  end

  assign cnt_rd_o  = cnt_rd_q;
  assign cnt_wr_o  = cnt_wr_q;
  assign cnt_rmw_o = cnt_rmw_q;
`else
  logic unused_cnt_clr;

  assign unused_cnt_clr = cnt_clr_i;
  assign cnt_rd_o       = '0;
  assign cnt_wr_o       = '0;
  assign cnt_rmw_o      = '0;
`endif

endmodule

// File: tb/tb_hci_mem_bank_rmw.sv
// -----------------------------------------------------------------------------
// tb_hci_mem_bank_rmw
//
// Directed bench for hci_mem_bank_rmw with a behavioural single-port SRAM.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on
// the falling edge. Expected response data sits in exp_q and is popped when a
// response is checked.
// -----------------------------------------------------------------------------
module tb_hci_mem_bank_rmw;

  localparam int DW = 32;
  localparam int BW = 8;
  localparam int AW = 10;
  localparam int IW = 8;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  logic clear;

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // DUT
  // ---------------------------------------------------------------------------
  hci_mem_bank_rmw_if #(.DW(DW), .BW(BW), .AW(AW), .IW(IW)) tcdm ();

  logic          sram_req;
  logic          sram_we;
  logic [AW-1:0] sram_add;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;
  logic          cnt_clr;
  logic [31:0]   cnt_rd;
  logic [31:0]   cnt_wr;
  logic [31:0]   cnt_rmw;
  logic [0:0]    dbg_state;

  hci_mem_bank_rmw #(.DW(DW), .BW(BW), .AW(AW), .IW(IW)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .clear_i      (clear),
    .tcdm         (tcdm),
    .sram_req_o   (sram_req),
    .sram_we_o    (sram_we),
    .sram_add_o   (sram_add),
    .sram_wdata_o (sram_wdata),
    .sram_rdata_i (sram_rdata),
    .cnt_clr_i    (cnt_clr),
    .cnt_rd_o     (cnt_rd),
    .cnt_wr_o     (cnt_wr),
    .cnt_rmw_o    (cnt_rmw),
    .dbg_state_o  (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // SRAM model with a bench-only preload port
  // ---------------------------------------------------------------------------
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_add = '0;
  logic [DW-1:0] pre_data = '0;
  int            wr_count = 0;

  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_add] <= pre_data;
    end else if (sram_req) begin
      if (sram_we) begin
        mem[sram_add] <= sram_wdata;
        wr_count      <= wr_count + 1;
      end else begin
        sram_rdata <= mem[sram_add];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Checks the response visible this cycle against the oldest queued data.
  task automatic check_rsp(input string tag, input logic [IW-1:0] id);
    logic [DW-1:0] exp;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    check_eq({tag, "_valid"}, tcdm.r_valid_o, 1);
    check_eq({tag, "_data"},  tcdm.r_data_o,  exp);
    check_eq({tag, "_id"},    tcdm.r_id_o,    id);
  endtask

  // Counter expectation: the traffic count with stats built in, 0 otherwise.
  function automatic logic [31:0] st(input logic [31:0] v);
`ifdef HCI_MEM_BANK_STATS_EN
    return v;
`else
    return (v & 32'd0);
`endif
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_bus();
    tcdm.req_i  = 1'b0;
    tcdm.add_i  = '0;
    tcdm.wen_i  = 1'b1;
    tcdm.be_i   = '0;
    tcdm.data_i = '0;
    tcdm.id_i   = '0;
  endtask

  task automatic drive(input logic [AW-1:0] a, input logic w, input logic [3:0] b,
                       input logic [DW-1:0] d, input logic [IW-1:0] i);
    tcdm.req_i  = 1'b1;
    tcdm.add_i  = a;
    tcdm.wen_i  = w;
    tcdm.be_i   = b;
    tcdm.data_i = d;
    tcdm.id_i   = i;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_we   = 1'b1;
    pre_add  = a;
    pre_data = d;
    next_cycle();
    pre_we   = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int wr_snap;

  initial begin
    idle_bus();
    rst     = 1'b1;
    clear   = 1'b0;
    cnt_clr = 1'b0;
    next_cycle();
    next_cycle();

    // Reset values
    sample();
    check_eq("rst_gnt",     tcdm.gnt_o,     1);
    check_eq("rst_r_valid", tcdm.r_valid_o, 0);
    check_eq("rst_r_data",  tcdm.r_data_o,  0);
    check_eq("rst_r_id",    tcdm.r_id_o,    0);
    check_eq("rst_state",   dbg_state,      0);
    check_eq("rst_sram_req", sram_req,      0);
    check_eq("rst_cnt_rd",  cnt_rd,         0);
    check_eq("rst_cnt_wr",  cnt_wr,         0);
    check_eq("rst_cnt_rmw", cnt_rmw,        0);
    next_cycle();
    rst = 1'b0;
    next_cycle();

    preload(10'h010, 32'hDEADBEEF);
    preload(10'h030, 32'hAABBCCDD);
    preload(10'h050, 32'h01020304);
    preload(10'h060, 32'h0A0B0C0D);

    // Read
    drive(10'h010, 1'b1, 4'h0, 32'h0, 8'h05);
    exp_q.push_back(32'hDEADBEEF);
    sample();
    check_eq("rd_gnt",     tcdm.gnt_o, 1);
    check_eq("rd_sram_req", sram_req,  1);
    check_eq("rd_sram_we", sram_we,    0);
    next_cycle();
    idle_bus();
    sample();
    check_rsp("rd_rsp", 8'h05);
    check_eq("rd_rsp_gnt", tcdm.gnt_o, 1);
    next_cycle();

    // Full write then back-to-back read
    drive(10'h020, 1'b0, 4'hF, 32'h12345678, 8'h01);
    exp_q.push_back(32'h0);
    sample();
    check_eq("fw_gnt",      tcdm.gnt_o, 1);
    check_eq("fw_sram_we",  sram_we,    1);
    check_eq("fw_sram_wd",  sram_wdata, 32'h12345678);
    next_cycle();
    drive(10'h020, 1'b1, 4'h0, 32'h0, 8'h02);
    exp_q.push_back(32'h12345678);
    sample();
    check_eq("fw_rd_gnt", tcdm.gnt_o, 1);
    check_rsp("fw_rsp", 8'h01);
    next_cycle();
    idle_bus();
    sample();
    check_rsp("fw_rd_rsp", 8'h02);
    next_cycle();

    // Partial write with a held read of the same address behind it
    drive(10'h030, 1'b0, 4'h5, 32'h11223344, 8'h03);
    sample();
    check_eq("pw_gnt",      tcdm.gnt_o, 1);
    check_eq("pw_sram_req", sram_req,   1);
    check_eq("pw_sram_we",  sram_we,    0);
    check_eq("pw_sram_add", sram_add,   10'h030);
    next_cycle();
    drive(10'h030, 1'b1, 4'h0, 32'h0, 8'h04);
    exp_q.push_back(32'h0);
    sample();
    check_eq("pw_merge_gnt",   tcdm.gnt_o, 0);
    check_eq("pw_merge_state", dbg_state,  1);
    check_eq("pw_merge_req",   sram_req,   1);
    check_eq("pw_merge_we",    sram_we,    1);
    check_eq("pw_merge_add",   sram_add,   10'h030);
    check_eq("pw_merge_wd",    sram_wdata, 32'hAA22CC44);
    check_rsp("pw_rsp", 8'h03);
    next_cycle();
    exp_q.push_back(32'hAA22CC44);
    sample();
    check_eq("pw_held_gnt", tcdm.gnt_o, 1);
    check_eq("pw_held_we",  sram_we,    0);
    next_cycle();
    idle_bus();
    sample();
    check_rsp("pw_rd_rsp", 8'h04);
    check_eq("pw_mem", mem[10'h030], 32'hAA22CC44);
    next_cycle();

    // Zero-byte write
    drive(10'h040, 1'b0, 4'h0, 32'hCAFEF00D, 8'h06);
    exp_q.push_back(32'h0);
    sample();
    check_eq("zb_gnt",      tcdm.gnt_o, 1);
    check_eq("zb_sram_req", sram_req,   0);
    check_eq("zb_cnt_wr_before", cnt_wr, st(32'd2));
    next_cycle();
    idle_bus();
    sample();
    check_rsp("zb_rsp", 8'h06);
    check_eq("zb_cnt_wr",  cnt_wr,  st(32'd3));
    check_eq("zb_cnt_rd",  cnt_rd,  st(32'd3));
    check_eq("zb_cnt_rmw", cnt_rmw, st(32'd1));
    next_cycle();

    // Reset during MERGE
    wr_snap = wr_count;
    drive(10'h050, 1'b0, 4'h3, 32'hFFFFFFFF, 8'h07);
    next_cycle();
    idle_bus();
    rst = 1'b1;
    sample();
    check_eq("mrst_gnt",     tcdm.gnt_o,     1);
    check_eq("mrst_r_valid", tcdm.r_valid_o, 0);
    check_eq("mrst_r_data",  tcdm.r_data_o,  0);
    check_eq("mrst_r_id",    tcdm.r_id_o,    0);
    check_eq("mrst_state",   dbg_state,      0);
    check_eq("mrst_sram_req", sram_req,      0);
    next_cycle();
    rst = 1'b0;
    sample();
    check_eq("mrst_mem",    mem[10'h050], 32'h01020304);
    check_eq("mrst_nowr",   wr_count,     wr_snap);
    check_eq("mrst_cnt_wr", cnt_wr,       0);
    next_cycle();

    // Clear during MERGE
    drive(10'h060, 1'b0, 4'hC, 32'h99887766, 8'h08);
    next_cycle();
    idle_bus();
    clear = 1'b1;
    sample();
    check_eq("mclr_state",   dbg_state,      1);
    check_eq("mclr_gnt",     tcdm.gnt_o,     0);
    check_eq("mclr_sram_req", sram_req,      0);
    check_eq("mclr_r_valid", tcdm.r_valid_o, 0);
    next_cycle();
    clear = 1'b0;
    sample();
    check_eq("mclr_state_after", dbg_state,      0);
    check_eq("mclr_r_valid_after", tcdm.r_valid_o, 0);
    check_eq("mclr_mem", mem[10'h060], 32'h0A0B0C0D);
    next_cycle();

    // Clear in IDLE drops the request
    drive(10'h010, 1'b1, 4'h0, 32'h0, 8'h09);
    clear = 1'b1;
    sample();
    check_eq("iclr_sram_req", sram_req, 0);
    next_cycle();
    idle_bus();
    clear = 1'b0;
    sample();
    check_eq("iclr_r_valid", tcdm.r_valid_o, 0);
    // Since the mid-MERGE reset: only the cleared partial write was granted.
    check_eq("iclr_cnt_rd",  cnt_rd,  st(32'd0));
    check_eq("iclr_cnt_wr",  cnt_wr,  st(32'd1));
    check_eq("iclr_cnt_rmw", cnt_rmw, st(32'd1));
    next_cycle();

    // Counter clear wins over a same-cycle read
    drive(10'h010, 1'b1, 4'h0, 32'h0, 8'h0A);
    cnt_clr = 1'b1;
    next_cycle();
    idle_bus();
    cnt_clr = 1'b0;
    sample();
    check_eq("clr_prio_rd", cnt_rd, 0);
    check_eq("clr_prio_wr", cnt_wr, 0);
    next_cycle();

    // Stats traffic: 3 reads, 2 full writes, 1 partial write
    drive(10'h010, 1'b1, 4'h0, 32'h0, 8'h10);          next_cycle();
    drive(10'h020, 1'b1, 4'h0, 32'h0, 8'h11);          next_cycle();
    drive(10'h070, 1'b0, 4'hF, 32'h00000070, 8'h12);   next_cycle();
    drive(10'h030, 1'b1, 4'h0, 32'h0, 8'h13);          next_cycle();
    drive(10'h071, 1'b0, 4'hF, 32'h00000071, 8'h14);   next_cycle();
    drive(10'h072, 1'b0, 4'h1, 32'h000000FF, 8'h15);   next_cycle();
    idle_bus();
    next_cycle();
    sample();
    check_eq("st_cnt_rd",  cnt_rd,  st(32'd3));
    check_eq("st_cnt_wr",  cnt_wr,  st(32'd3));
    check_eq("st_cnt_rmw", cnt_rmw, st(32'd1));
    check_eq("st_mem_fw",  mem[10'h071], 32'h00000071);
    next_cycle();
    cnt_clr = 1'b1;
    next_cycle();
    cnt_clr = 1'b0;
    sample();
    check_eq("st_clr_rd",  cnt_rd,  0);
    check_eq("st_clr_wr",  cnt_wr,  0);
    check_eq("st_clr_rmw", cnt_rmw, 0);
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
